// File: rtl/carregador_matriz_pkg.sv
// ----------------------------------------------------------------------------
// carregador_matriz_pkg : shared constants and loader state encodings
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package carregador_matriz_pkg;

    localparam int N_ELEM         = 25;
    localparam int LARGURA_ELEM   = 8;
    localparam int LARGURA_MATRIZ = N_ELEM * LARGURA_ELEM;
    localparam int LARGURA_END    = 3;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        RECEBE = 2'd1,
        GRAVA  = 2'd2,
        FIM    = 2'd3
    } estado_t;

endpackage

`default_nettype wire

// File: rtl/carregador_matriz.sv
// ----------------------------------------------------------------------------
// carregador_matriz : packs a 5x5 byte stream into one RAM word per matrix
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module carregador_matriz #(
    parameter int LARGURA_ELEM = 8,
    parameter int N_ELEM       = 25,
    parameter int LARGURA_END  = 3
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             iniciar,
    input  logic [LARGURA_END-1:0]           endereco_base,
    input  logic [1:0]                       n_matrizes,
    input  logic                             byte_valido,
    input  logic [LARGURA_ELEM-1:0]          byte_dado,
    output logic                             byte_pronto,
    output logic [LARGURA_END-1:0]           mem_endereco,
    output logic [N_ELEM*LARGURA_ELEM-1:0]   mem_dado,
    output logic                             mem_escrita,
    output logic                             ocupado,
    output logic                             concluido
);

    import carregador_matriz_pkg::*;

    localparam int LARGURA_BUF = N_ELEM * LARGURA_ELEM;
    localparam int IDX_W       = $clog2(N_ELEM);
    localparam logic [IDX_W-1:0] ULTIMO = IDX_W'(N_ELEM - 1);

    estado_t                  estado, estado_prox;
    logic [IDX_W-1:0]         idx, idx_prox;
    logic [LARGURA_BUF-1:0]   buffer, buffer_prox;
    logic [LARGURA_END-1:0]   end_atual, end_prox;
    logic [2:0]               restantes, rest_prox;
    logic [LARGURA_BUF-1:0]   dado_prox;
    logic [LARGURA_END-1:0]   endm_prox;

    always_comb begin
        estado_prox = estado;
        idx_prox    = idx;
        buffer_prox = buffer;
        end_prox    = end_atual;
        rest_prox   = restantes;
        dado_prox   = mem_dado;
        endm_prox   = mem_endereco;

        case (estado)
            OCIOSO: begin
                if (iniciar) begin
                    end_prox    = endereco_base;
                    rest_prox   = (n_matrizes == 2'd0) ? 3'd4 : {1'b0, n_matrizes};
                    idx_prox    = '0;
                    buffer_prox = '0;
                    estado_prox = RECEBE;
                end
            end
            RECEBE: begin
                if (byte_valido && byte_pronto) begin
                    buffer_prox[LARGURA_ELEM*int'(idx) +: LARGURA_ELEM] = byte_dado;
                    if (idx == ULTIMO) begin
                        // Latch the completed word so the RAM sees it with the write strobe.
                        idx_prox    = '0;
                        dado_prox   = buffer_prox;
                        endm_prox   = end_atual;
                        estado_prox = GRAVA;
                    end else begin
                        idx_prox = idx + 1'b1;
                    end
                end
            end
            GRAVA: begin
                rest_prox = restantes - 3'd1;
                if (restantes > 3'd1) begin
                    end_prox    = end_atual + 1'b1;
                    idx_prox    = '0;
                    buffer_prox = '0;
                    estado_prox = RECEBE;
                end else begin
                    estado_prox = FIM;
                end
            end
            FIM: begin
                estado_prox = OCIOSO;
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado       <= OCIOSO;
            idx          <= '0;
            buffer       <= '0;
            end_atual    <= '0;
            restantes    <= '0;
            mem_dado     <= '0;
            mem_endereco <= '0;
            byte_pronto  <= 1'b0;
            mem_escrita  <= 1'b0;
            ocupado      <= 1'b0;
            concluido    <= 1'b0;
        end else begin
            estado       <= estado_prox;
            idx          <= idx_prox;
            buffer       <= buffer_prox;
            end_atual    <= end_prox;
            restantes    <= rest_prox;
            mem_dado     <= dado_prox;
            mem_endereco <= endm_prox;
            // Outputs are decoded from the next state so they change with the state itself.
            byte_pronto  <= (estado_prox == RECEBE);
            mem_escrita  <= (estado_prox == GRAVA);
            ocupado      <= (estado_prox != OCIOSO);
            concluido    <= (estado_prox == FIM);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_carregador_matriz.sv
// ----------------------------------------------------------------------------
// tb_carregador_matriz : directed self-checking bench for carregador_matriz
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_carregador_matriz;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         iniciar = 1'b0;
    logic [2:0]   endereco_base = 3'd0;
    logic [1:0]   n_matrizes = 2'd0;
    logic         byte_valido = 1'b0;
    logic [7:0]   byte_dado = 8'd0;
    logic         byte_pronto;
    logic [2:0]   mem_endereco;
    logic [199:0] mem_dado;
    logic         mem_escrita;
    logic         ocupado;
    logic         concluido;

    int checks = 0;
    int errors = 0;

    carregador_matriz dut (
        .clock         (clock),
        .reset         (reset),
        .iniciar       (iniciar),
        .endereco_base (endereco_base),
        .n_matrizes    (n_matrizes),
        .byte_valido   (byte_valido),
        .byte_dado     (byte_dado),
        .byte_pronto   (byte_pronto),
        .mem_endereco  (mem_endereco),
        .mem_dado      (mem_dado),
        .mem_escrita   (mem_escrita),
        .ocupado       (ocupado),
        .concluido     (concluido)
    );

    always #5 clock = ~clock;

    // Write/transfer/done monitor.
    int           cyc = 0;
    int           xfers = 0;
    int           conc_n = 0;
    int           conc_cycle = 0;
    logic [2:0]   wr_addr[$];
    logic [199:0] wr_data[$];
    int           wr_cycle[$];
    int           wr_xf[$];

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!reset && byte_valido && byte_pronto) xfers <= xfers + 1;
    end

    always @(negedge clock) begin
        if (mem_escrita) begin
            wr_addr.push_back(mem_endereco);
            wr_data.push_back(mem_dado);
            wr_cycle.push_back(cyc);
            wr_xf.push_back(xfers);
        end
        if (concluido) begin
            conc_n     = conc_n + 1;
            conc_cycle = cyc;
        end
    end

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   n = 0;
        logic aceito = 1'b0;
        byte_valido = 1'b1;
        byte_dado   = b;
        while (!aceito && n < 100) begin
            aceito = byte_pronto;
            step();
            n++;
        end
        check("handshake", {199'd0, aceito}, 200'd1);
        byte_valido = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (ocupado && n < 300) begin
            step();
            n++;
        end
        check("idle_timeout", {199'd0, ocupado}, 200'd0);
    endtask

    task automatic start(input logic [2:0] base, input logic [1:0] n);
        endereco_base = base;
        n_matrizes    = n;
        iniciar       = 1'b1;
        step();
        iniciar       = 1'b0;
    endtask

    function automatic logic [199:0] seq_word(input int first);
        logic [199:0] w;
        for (int i = 0; i < 25; i++) w[8*i +: 8] = 8'(first + i);
        return w;
    endfunction

    function automatic logic [199:0] fill_word(input logic [7:0] v);
        logic [199:0] w;
        for (int i = 0; i < 25; i++) w[8*i +: 8] = v;
        return w;
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pronto"},   {199'd0, byte_pronto}, 200'd0);
        check({tag, "_escrita"},  {199'd0, mem_escrita}, 200'd0);
        check({tag, "_ocupado"},  {199'd0, ocupado},     200'd0);
        check({tag, "_concluido"},{199'd0, concluido},   200'd0);
        check({tag, "_endereco"}, {197'd0, mem_endereco},200'd0);
        check({tag, "_dado"},     mem_dado,              200'd0);
    endtask

    int           w0;
    int           c0;
    int           x0;
    logic         ff_seen;
    logic [199:0] w;

    initial begin
        // Reset state
        repeat (3) step();
        check_outputs_zero("reset");
        reset = 1'b0;
        step();

        // 1: single matrix, bytes 1..25 back-to-back
        w0 = wr_addr.size(); c0 = conc_n;
        start(3'd0, 2'd1);
        check("s1_pronto_after_iniciar", {199'd0, byte_pronto}, 200'd1);
        check("s1_ocupado", {199'd0, ocupado}, 200'd1);
        for (int i = 1; i <= 25; i++) send_byte(8'(i));
        check("s1_escrita_t1", {199'd0, mem_escrita}, 200'd1);
        check("s1_pronto_t1", {199'd0, byte_pronto}, 200'd0);
        wait_idle();
        check("s1_n_writes", 200'(wr_addr.size() - w0), 200'd1);
        check("s1_addr", {197'd0, wr_addr[w0]}, 200'd0);
        w = wr_data[w0];
        check("s1_byte0", {192'd0, w[7:0]}, 200'd1);
        check("s1_byte1", {192'd0, w[15:8]}, 200'd2);
        check("s1_byte24", {192'd0, w[199:192]}, 200'd25);
        check("s1_word", w, seq_word(1));
        check("s1_n_concluido", 200'(conc_n - c0), 200'd1);
        check("s1_concluido_lat", 200'(conc_cycle - wr_cycle[w0]), 200'd1);
        check("s1_dado_held", mem_dado, seq_word(1));

        // 2: two matrices, base 7 wraps to 0
        w0 = wr_addr.size(); c0 = conc_n;
        start(3'd7, 2'd2);
        for (int i = 0; i < 25; i++) send_byte(8'hAA);
        check("s2_escrita_t1", {199'd0, mem_escrita}, 200'd1);
        check("s2_pronto_t1", {199'd0, byte_pronto}, 200'd0);
        step();
        check("s2_pronto_t2", {199'd0, byte_pronto}, 200'd1);
        check("s2_escrita_t2", {199'd0, mem_escrita}, 200'd0);
        for (int i = 0; i < 25; i++) send_byte(8'h55);
        wait_idle();
        check("s2_n_writes", 200'(wr_addr.size() - w0), 200'd2);
        check("s2_addr0", {197'd0, wr_addr[w0]}, 200'd7);
        check("s2_data0", wr_data[w0], fill_word(8'hAA));
        check("s2_addr1", {197'd0, wr_addr[w0+1]}, 200'd0);
        check("s2_data1", wr_data[w0+1], fill_word(8'h55));
        check("s2_n_concluido", 200'(conc_n - c0), 200'd1);

        // 3: gapped source, 3 idle cycles after every 4th byte
        w0 = wr_addr.size(); x0 = xfers;
        start(3'd1, 2'd1);
        for (int i = 1; i <= 25; i++) begin
            send_byte(8'(i));
            if (i % 4 == 0) repeat (3) step();
        end
        wait_idle();
        check("s3_n_writes", 200'(wr_addr.size() - w0), 200'd1);
        check("s3_word", wr_data[w0], seq_word(1));
        check("s3_xfers_at_write", 200'(wr_xf[w0] - x0), 200'd25);
        check("s3_addr", {197'd0, wr_addr[w0]}, 200'd1);

        // 4: count 0 means four matrices; stray iniciar mid-RECEBE
        w0 = wr_addr.size(); c0 = conc_n;
        start(3'd2, 2'd0);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 25; i++) begin
                send_byte(8'(8'h10 + k));
                if (k == 0 && i == 4) begin
                    endereco_base = 3'd6;
                    n_matrizes    = 2'd1;
                    iniciar       = 1'b1;
                    step();
                    iniciar       = 1'b0;
                end
            end
        end
        wait_idle();
        check("s4_n_writes", 200'(wr_addr.size() - w0), 200'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("s4_addr%0d", k), {197'd0, wr_addr[w0+k]}, 200'(2 + k));
            check($sformatf("s4_data%0d", k), wr_data[w0+k], fill_word(8'(8'h10 + k)));
        end
        check("s4_n_concluido", 200'(conc_n - c0), 200'd1);

        // 5: reset mid-load aborts without a write
        w0 = wr_addr.size();
        start(3'd3, 2'd1);
        for (int i = 0; i < 10; i++) send_byte(8'hC0);
        byte_valido = 1'b1;
        byte_dado   = 8'hC0;
        reset       = 1'b1;
        step();
        byte_valido = 1'b0;
        check_outputs_zero("s5_reset");
        reset = 1'b0;
        step();
        check("s5_no_write", 200'(wr_addr.size() - w0), 200'd0);
        start(3'd1, 2'd1);
        for (int i = 0; i < 25; i++) send_byte(8'(100 + i));
        wait_idle();
        check("s5_n_writes", 200'(wr_addr.size() - w0), 200'd1);
        w = wr_data[w0];
        check("s5_byte0", {192'd0, w[7:0]}, 200'd100);
        check("s5_word", w, seq_word(100));

        // 6: valid while idle is ignored
        w0 = wr_addr.size();
        byte_valido = 1'b1;
        byte_dado   = 8'hFF;
        repeat (3) step();
        check("s6_pronto_idle", {199'd0, byte_pronto}, 200'd0);
        check("s6_ocupado_idle", {199'd0, ocupado}, 200'd0);
        start(3'd4, 2'd1);
        for (int i = 1; i <= 25; i++) send_byte(8'(i));
        wait_idle();
        check("s6_n_writes", 200'(wr_addr.size() - w0), 200'd1);
        w = wr_data[w0];
        ff_seen = 1'b0;
        for (int i = 0; i < 25; i++) if (w[8*i +: 8] == 8'hFF) ff_seen = 1'b1;
        check("s6_no_ff", {199'd0, ff_seen}, 200'd0);
        check("s6_word", w, seq_word(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/carregador_matriz.md
# carregador_matriz

Upstream loader for the matrix coprocessor. It receives 5x5 matrices of 8-bit elements as a byte stream over a valid/ready handshake and packs each matrix into one 200-bit word. It writes that word into the 200-bit-wide matrix RAM at consecutive addresses. The control FSM then reads operands A and B from that RAM.

## Interface
- `LARGURA_ELEM`, default 8: element width in bits.
- `N_ELEM`, default 25: elements per matrix (5x5, row-major).
- `LARGURA_END`, default 3: RAM address width (8 words).
- `clock` input, 1 bit: single system clock, rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `iniciar` input, 1 bit: start a load; sampled only in OCIOSO.
- `endereco_base` input, 3 bits: first RAM address; latched on `iniciar`.
- `n_matrizes` input, 2 bits: number of matrices to load; 0 means 4. Latched on `iniciar`.
- `byte_valido` input, 1 bit: the source has a valid element on `byte_dado`.
- `byte_dado` input, 8 bits: element value; the first byte is element 0 (row 0, col 0).
- `byte_pronto` output, 1 bit: loader accepts an element; a transfer occurs when `byte_valido & byte_pronto`.
- `mem_endereco` output, 3 bits: RAM address.
- `mem_dado` output, 200 bits: packed matrix; element i at bits [8i +: 8].
- `mem_escrita` output, 1 bit: RAM write enable, one cycle per matrix.
- `ocupado` output, 1 bit: high in every state except OCIOSO.
- `concluido` output, 1 bit: one-cycle pulse after the last write.

## Operation
- Element i = 5*linha + coluna. Element 0 lands in bits [7:0], which is the scalar slot the operation unit uses from matrix B.
- FSM states, all outputs registered:
  - OCIOSO:
    - `byte_pronto` = 0 and `mem_escrita` = 0.
    - On `iniciar`: latch base address and count (0 maps to 4), clear the element index and the pack buffer, go to RECEBE.
  - RECEBE:
    - `byte_pronto` = 1.
    - On each transfer, write `byte_dado` into slot idx and increment idx.
    - A transfer with idx = 24 goes to GRAVA.
  - GRAVA:
    - `mem_escrita` = 1 for exactly one cycle; `mem_endereco` = current address and `mem_dado` = full buffer.
    - If matrices remain: address += 1 modulo 8, idx = 0, buffer cleared, back to RECEBE.
    - Otherwise go to FIM.
  - FIM: `concluido` = 1 for one cycle, then OCIOSO.
- Address wrap: base 7 followed by a second matrix writes address 0. No error is raised.
- `iniciar` is ignored outside OCIOSO. `byte_valido` is ignored whenever `byte_pronto` = 0.
- `reset` in any state:
  - Go to OCIOSO and discard the partial matrix; no write is issued.
  - idx, buffer, `mem_dado`, `mem_endereco` and the count are cleared.
- Reset value of every output: 0.
- `mem_dado` and `mem_endereco` stay at their last written values until the next GRAVA or reset. The RAM may therefore sample them on the write edge or the following edge.

## Timing
- `iniciar` at edge t puts `byte_pronto` = 1 from t+1.
- Element transfers: one per cycle maximum; a gapped `byte_valido` is tolerated at any point.
- Accepting the 25th byte at edge t:
  - From t+1: `byte_pronto` = 0 and `mem_escrita` = 1.
  - From t+2: `byte_pronto` = 1 again if matrices remain.
- Minimum cost per matrix: 26 cycles (25 transfers plus 1 write).
- `concluido` is high for the cycle after the final GRAVA; `ocupado` falls on the same edge that `concluido` falls.
- `iniciar` held high across FIM is not re-accepted until the cycle the FSM is in OCIOSO. If it is still high then, a new load starts.

## Structure
- Shared package, shared with the operation unit and the control FSM:
  - constants `N_ELEM` = 25, `LARGURA_ELEM` = 8, `LARGURA_MATRIZ` = 200, `LARGURA_END` = 3;
  - the loader state encodings OCIOSO/RECEBE/GRAVA/FIM.
- Single module, no sub-module. Packing is an indexed part-select write into the 200-bit buffer, and splitting it out gives no reuse.

## Test plan
1. Reset; `n_matrizes`=1, `endereco_base`=0; bytes 1..25 sent back-to-back. Required:
   - exactly one `mem_escrita` pulse at address 0;
   - `mem_dado[7:0]`=1, `mem_dado[15:8]`=2, `mem_dado[199:192]`=25;
   - `concluido` one cycle after the write.
2. `n_matrizes`=2, base=7; two matrices of all 0xAA then all 0x55. Required: writes to address 7 (all 0xAA), then address 0 (all 0x55), then one `concluido`.
3. Same data as scenario 1 with `byte_valido` deasserted for 3 cycles after every 4th byte. Required: identical packed word; `mem_escrita` never asserts before the 25th transfer.
4. `n_matrizes`=0, base=2. Required: four writes to addresses 2, 3, 4, 5. A second `iniciar` pulsed mid-RECEBE has no effect.
5. `reset` asserted after 10 bytes; then a fresh load with bytes 100..124. Required:
   - no write during the aborted load;
   - all outputs 0 after the reset;
   - the new word has `mem_dado[7:0]`=100.
6. `byte_valido`=1 with `byte_dado`=0xFF while in OCIOSO, then `iniciar` with bytes 1..25. Required: 0xFF never appears in `mem_dado`.
